// File: rtl/mul_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : mul_share_arb
//  Description : Round-robin scheduler sharing one pipelined signed multiplier
//                among N_REQ requesters. Each requester may have one operation
//                outstanding. Issued operations are tagged through the
//                multiplier latency. The carry-save output pair is resolved on
//                return, and the product is parked in a per-requester
//                one-deep result buffer.
//  Ports       : clk, rst_n            clock, async active-low reset
//                req_valid/a/b         per-requester operand handshake (in)
//                req_ready             one-hot grant (combinational)
//                res_valid/data/ready  per-requester result handshake
//                mul_valid/a/b         registered issue to the multiplier
//                mul_cout/mul_sum      carry-save multiplier result (in)
//                busy                  any op in flight or result buffered
//  Revision    : 1.0  initial release
// ============================================================================
module mul_share_arb #(
   parameter int WIDTH_DATA = 16,
   parameter int N_REQ      = 4,
   parameter int MUL_LAT    = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N_REQ-1:0]              req_valid,
   input  logic [N_REQ*WIDTH_DATA-1:0]   req_a,
   input  logic [N_REQ*WIDTH_DATA-1:0]   req_b,
   output logic [N_REQ-1:0]              req_ready,
   output logic [N_REQ-1:0]              res_valid,
   output logic [N_REQ*2*WIDTH_DATA-1:0] res_data,
   input  logic [N_REQ-1:0]              res_ready,
   output logic                          mul_valid,
   output logic [WIDTH_DATA-1:0]         mul_a,
   output logic [WIDTH_DATA-1:0]         mul_b,
   input  logic [2*WIDTH_DATA-1:0]       mul_cout,
   input  logic [2*WIDTH_DATA-1:0]       mul_sum,
   output logic                          busy
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int PW    = 2 * WIDTH_DATA;
   // Tag stage 0 lines up with mul_a/mul_b; the tail lines up with cout/sum.
   localparam int TAG_D = MUL_LAT + 1;

   logic [N_REQ-1:0]      inflight_q, inflight_d;
   logic [N_REQ-1:0]      res_full_q, res_full_d;
   logic [IDX_W-1:0]      last_q, last_d;
   logic                  mul_valid_q, mul_valid_d;
   logic [WIDTH_DATA-1:0] mul_a_q, mul_a_d;
   logic [WIDTH_DATA-1:0] mul_b_q, mul_b_d;
   logic [TAG_D-1:0]      tag_v_q, tag_v_d;
   logic [IDX_W-1:0]      tag_idx_q [TAG_D];
   logic [IDX_W-1:0]      tag_idx_d [TAG_D];
   logic [PW-1:0]         res_data_q [N_REQ];
   logic [PW-1:0]         res_data_d [N_REQ];

   logic [N_REQ-1:0]      eligible;
   logic [N_REQ-1:0]      grant;
   logic [IDX_W-1:0]      grant_idx;
   logic                  fire;
   logic [PW-1:0]         product;
   int                    cand;

   // Eligibility uses registered state only, so a requester popped this
   // cycle does not become eligible until the next cycle.
   always_comb begin
      eligible  = req_valid & ~inflight_q & ~res_full_q;
      grant     = '0;
      grant_idx = last_q;
      fire      = 1'b0;
      cand      = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = int'(last_q) + k;
         if (cand >= N_REQ) cand = cand - N_REQ;
         if (!fire && eligible[IDX_W'(cand)]) begin
            fire                  = 1'b1;
            grant_idx             = IDX_W'(cand);
            grant[IDX_W'(cand)]   = 1'b1;
         end
      end
   end

   // Carry-save resolve; the carry bit shifted past the top is dropped.
   assign product = mul_sum + (mul_cout << 1);

   always_comb begin
      inflight_d  = inflight_q;
      res_full_d  = res_full_q & ~res_ready;
      res_data_d  = res_data_q;
      last_d      = last_q;
      mul_valid_d = fire;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      tag_v_d     = {tag_v_q[TAG_D-1:0] << 1} | {{(TAG_D-1){1'b0}}, fire};
      tag_idx_d   = tag_idx_q;
      tag_idx_d[0] = grant_idx;
      for (int s = 1; s < TAG_D; s++) begin
         tag_idx_d[s] = tag_idx_q[s-1];
      end

      if (tag_v_q[TAG_D-1]) begin
         inflight_d[tag_idx_q[TAG_D-1]] = 1'b0;
         res_full_d[tag_idx_q[TAG_D-1]] = 1'b1;
         res_data_d[tag_idx_q[TAG_D-1]] = product;
      end

      if (fire) begin
         inflight_d[grant_idx] = 1'b1;
         last_d                = grant_idx;
         for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
               mul_a_d = req_a[i*WIDTH_DATA +: WIDTH_DATA];
               mul_b_d = req_b[i*WIDTH_DATA +: WIDTH_DATA];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q  <= '0;
         res_full_q  <= '0;
         last_q      <= IDX_W'(N_REQ - 1);
         mul_valid_q <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         tag_v_q     <= '0;
         for (int s = 0; s < TAG_D; s++) tag_idx_q[s] <= '0;
         for (int i = 0; i < N_REQ; i++) res_data_q[i] <= '0;
      end else begin
         inflight_q  <= inflight_d;
         res_full_q  <= res_full_d;
         last_q      <= last_d;
         mul_valid_q <= mul_valid_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         tag_v_q     <= tag_v_d;
         tag_idx_q   <= tag_idx_d;
         res_data_q  <= res_data_d;
      end
   end

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_res_out
         assign res_data[gi*PW +: PW] = res_data_q[gi];
      end
   endgenerate

   assign req_ready = grant;
   assign res_valid = res_full_q;
   assign mul_valid = mul_valid_q;
   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign busy      = (|inflight_q) | (|res_full_q);

endmodule
`default_nettype wire

// File: tb/tb_mul_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_share_arb
//  Description : Self-checking bench for mul_share_arb with a carry-save
//                multiplier model, directed vectors and a randomized phase
//                checked against a transaction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mul_share_arb;
   localparam int W   = 16;
   localparam int N   = 4;
   localparam int LAT = 2;
   localparam int PW  = 2 * W;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid, req_ready, res_valid, res_ready;
   logic [N*W-1:0]  req_a, req_b;
   logic [N*PW-1:0] res_data;
   logic            mul_valid, busy;
   logic [W-1:0]    mul_a, mul_b;
   logic [PW-1:0]   mul_cout, mul_sum;

   logic            force_en = 1'b0;
   logic [PW-1:0]   force_cout = '0, force_sum = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mul_share_arb #(.WIDTH_DATA(W), .N_REQ(N), .MUL_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
      .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
      .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
      .mul_cout(mul_cout), .mul_sum(mul_sum), .busy(busy)
   );

   function automatic logic [PW-1:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [PW-1:0] x, y;
      x = $signed(a);
      y = $signed(b);
      return x * y;
   endfunction

   // Multiplier model: LAT-deep pipeline, cout random, sum = a*b - 2*cout.
   logic [PW-1:0] pp [LAT];
   logic [PW-1:0] pr [LAT];
   always @(posedge clk) begin
      pp[0] <= smul(mul_a, mul_b);
      pr[0] <= $urandom;
      for (int k = 1; k < LAT; k++) begin
         pp[k] <= pp[k-1];
         pr[k] <= pr[k-1];
      end
   end
   assign mul_cout = force_en ? force_cout : pr[LAT-1];
   assign mul_sum  = force_en ? force_sum  : pp[LAT-1] - (pr[LAT-1] << 1);

   function automatic logic [PW-1:0] get_res(input int i);
      return res_data[i*PW +: PW];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic reset_dut();
      req_valid = '0;
      res_ready = '0;
      rst_n     = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic drain();
      req_valid = '0;
      res_ready = '1;
      for (int k = 0; k < 50 && busy; k++) step();
      #1;
      chk("drain_busy", busy, 0);
      res_ready = '0;
   endtask

   typedef struct {
      logic [W-1:0]  a, b;
      bit            frc;
      logic [PW-1:0] cout, sum, exp;
   } vec_t;
   vec_t tbl [6];

   // Reference-model state for the random phase
   bit             out_m [N];
   int             due_m [N];
   logic [PW-1:0]  prod_m [N];
   int             last_m, g, cnt0, cnt2, cnt3, jj;
   bit             fired_prev, held_ok, r1_granted;
   logic [W-1:0]   prev_a, prev_b, a1, b1;
   logic [PW-1:0]  held;
   logic [N-1:0]   exp_rdy, exp_rv;

   initial begin
      tbl[0] = '{a: 16'd3,     b: 16'hFFFB, frc: 0, cout: 0, sum: 0, exp: 32'hFFFFFFF1};
      tbl[1] = '{a: 16'h8000,  b: 16'h8000, frc: 0, cout: 0, sum: 0, exp: 32'h40000000};
      tbl[2] = '{a: 16'h7FFF,  b: 16'h8000, frc: 0, cout: 0, sum: 0, exp: 32'hC0008000};
      tbl[3] = '{a: 16'hFFFF,  b: 16'hFFFF, frc: 0, cout: 0, sum: 0, exp: 32'h00000001};
      tbl[4] = '{a: 16'd7,     b: 16'd9,    frc: 1, cout: 32'h00008000, sum: 32'h00000001, exp: 32'h00010001};
      tbl[5] = '{a: 16'd7,     b: 16'd9,    frc: 1, cout: 32'hFFFFFFFF, sum: 32'h00000003, exp: 32'h00000001};

      req_a = '0;
      req_b = '0;
      rst_n = 1'b0;
      req_valid = '0;
      res_ready = '0;
      @(negedge clk);
      #1;
      chk("rst_ready", req_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_mul_valid", mul_valid, 0);
      chk("rst_mul_ab", {mul_a, mul_b}, 0);
      chk("rst_busy", busy, 0);
      step();
      rst_n = 1'b1;
      step();

      // Single-request vectors: latency, product and carry-save resolve
      for (int v = 0; v < 6; v++) begin
         force_en   = tbl[v].frc;
         force_cout = tbl[v].cout;
         force_sum  = tbl[v].sum;
         req_a[0 +: W] = tbl[v].a;
         req_b[0 +: W] = tbl[v].b;
         req_valid = 4'b0001;
         #1;
         chk("vec_grant", req_ready, 4'b0001);
         step();
         req_valid = '0;
         #1;
         chk("vec_busy_t1", busy, 1);
         chk("vec_mul_valid", mul_valid, 1);
         chk("vec_mul_ab", {mul_a, mul_b}, {tbl[v].a, tbl[v].b});
         step();
         step();
         #1;
         chk("vec_early_res", res_valid, 0);
         step();
         #1;
         chk("vec_res_valid_t4", res_valid, 4'b0001);
         chk("vec_res_data", get_res(0), tbl[v].exp);
         chk("vec_busy_held", busy, 1);
         res_ready = 4'b0001;
         step();
         res_ready = '0;
         #1;
         chk("vec_popped", res_valid, 0);
         chk("vec_idle", busy, 0);
         force_en = 1'b0;
      end

      // Round-robin order from reset with all requesters valid
      reset_dut();
      req_a = {$urandom, $urandom};
      req_b = {$urandom, $urandom};
      req_valid = '1;
      res_ready = '1;
      begin
         logic [N-1:0] rr_exp [8];
         rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0001, 4'b0010, 4'b0100};
         for (int c = 0; c < 8; c++) begin
            #1;
            chk("rr_order", req_ready, rr_exp[c]);
            step();
         end
      end
      drain();

      // Pointer fairness between requesters 2 and 3
      reset_dut();
      req_valid = 4'b0100;
      #1;
      chk("fair_first", req_ready, 4'b0100);
      step();
      req_valid = 4'b1100;
      #1;
      chk("fair_second", req_ready, 4'b1000);
      step();
      for (int c = 0; c < 6; c++) step();
      #1;
      chk("fair_both_full", res_valid, 4'b1100);
      res_ready = 4'b1100;
      step();
      res_ready = '1;
      #1;
      chk("fair_regrant2", req_ready, 4'b0100);
      step();
      #1;
      chk("fair_regrant3", req_ready, 4'b1000);
      step();
      drain();

      // Backpressure on requester 1
      reset_dut();
      req_a = {$urandom, $urandom};
      req_b = {$urandom, $urandom};
      a1 = req_a[W +: W];
      b1 = req_b[W +: W];
      req_valid = '1;
      res_ready = 4'b1101;
      held_ok = 0;
      r1_granted = 0;
      cnt0 = 0; cnt2 = 0; cnt3 = 0;
      for (int c = 0; c < 24; c++) begin
         #1;
         if (r1_granted) chk("bp_no_regrant", req_ready[1], 0);
         if (req_ready[1]) r1_granted = 1;
         if (req_ready[0]) cnt0++;
         if (req_ready[2]) cnt2++;
         if (req_ready[3]) cnt3++;
         if (res_valid[1]) begin
            if (held_ok) chk("bp_stable", get_res(1), held);
            else begin
               chk("bp_value", get_res(1), smul(a1, b1));
               held = get_res(1);
               held_ok = 1;
            end
         end
         step();
      end
      chk("bp_others_cycle", {cnt0 >= 3, cnt2 >= 3, cnt3 >= 3}, 3'b111);
      req_valid = 4'b0010;
      res_ready = '1;
      #1;
      chk("bp_pop_cycle", {res_valid[1], req_ready[1]}, 2'b10);
      step();
      #1;
      chk("bp_regrant", req_ready, 4'b0010);
      step();
      drain();

      // Reset in the middle of an operation
      reset_dut();
      req_valid = 4'b0010;
      req_a = {$urandom, $urandom};
      req_b = {$urandom, $urandom};
      #1;
      chk("rmf_fire", req_ready, 4'b0010);
      step();
      req_valid = '0;
      step();
      rst_n = 1'b0;
      #1;
      chk("rmf_in_rst", {res_valid, busy, mul_valid, mul_a, mul_b}, 0);
      step();
      step();
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #1;
         chk("rmf_quiet", {res_valid, busy}, 0);
         step();
      end
      req_valid = '1;
      #1;
      chk("rmf_prio0", req_ready, 4'b0001);
      req_valid = '0;
      step();

      // Randomized phase against the reference model
      reset_dut();
      last_m = N - 1;
      fired_prev = 0;
      prev_a = '0;
      prev_b = '0;
      for (int i = 0; i < N; i++) begin
         out_m[i] = 0;
         due_m[i] = 0;
         prod_m[i] = '0;
      end
      for (int it = 0; it < 400; it++) begin
         for (int i = 0; i < N; i++) begin
            req_valid[i] = ($urandom % 3) != 0;
            res_ready[i] = ($urandom % 4) != 0;
         end
         req_a = {$urandom, $urandom};
         req_b = {$urandom, $urandom};
         #1;
         g = -1;
         for (int k = 1; k <= N; k++) begin
            jj = (last_m + k) % N;
            if (g < 0 && req_valid[jj] && !out_m[jj]) g = jj;
         end
         exp_rdy = '0;
         if (g >= 0) exp_rdy[g] = 1'b1;
         for (int i = 0; i < N; i++) exp_rv[i] = out_m[i] && (it >= due_m[i]);
         chk("rnd_ready", req_ready, exp_rdy);
         chk("rnd_res_valid", res_valid, exp_rv);
         chk("rnd_busy", busy, (out_m[0] | out_m[1] | out_m[2] | out_m[3]));
         chk("rnd_mul_valid", mul_valid, fired_prev);
         chk("rnd_mul_ab", {mul_a, mul_b}, {prev_a, prev_b});
         for (int i = 0; i < N; i++) begin
            if (exp_rv[i]) chk("rnd_res_data", get_res(i), prod_m[i]);
            if (exp_rv[i] && res_ready[i]) out_m[i] = 0;
         end
         if (g >= 0) begin
            out_m[g]  = 1;
            due_m[g]  = it + LAT + 2;
            prod_m[g] = smul(req_a[g*W +: W], req_b[g*W +: W]);
            prev_a    = req_a[g*W +: W];
            prev_b    = req_b[g*W +: W];
            last_m    = g;
            fired_prev = 1;
         end else begin
            fired_prev = 0;
         end
         step();
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/mul_share_arb.md
# mul_share_arb

Round-robin scheduler that shares one pipelined Booth/Wallace signed multiplier among `N_REQ` conv1d requesters. It accepts operand pairs over valid/ready handshakes and issues at most one multiplication per cycle. It tracks each issued operation through the fixed-latency multiplier, resolves the carry-save `cout`/`sum` pair into a final product, and returns each product to its owner through a one-deep result buffer. It sits between the conv1d tap/MAC units and the single multiplier instance.

## Interface
Parameters:
- `WIDTH_DATA`, 16, operand width (signed two's complement); product width is `2*WIDTH_DATA`.
- `N_REQ`, 4, number of requesters (2..8).
- `MUL_LAT`, 2, cycles from `mul_a`/`mul_b` presented to `mul_cout`/`mul_sum` valid (0 = combinational multiplier).

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `req_valid`  in  `N_REQ`  per-requester operand valid.
- `req_a`, `req_b`  in  `N_REQ*WIDTH_DATA` each  operands. Requester i occupies bits `[(i+1)*WIDTH_DATA-1 -: WIDTH_DATA]`.
- `req_ready`  out  `N_REQ`  grant, one-hot or zero (combinational).
- `res_valid`  out  `N_REQ`  result buffer full.
- `res_data`  out  `N_REQ*2*WIDTH_DATA`  per-requester product.
- `res_ready`  in  `N_REQ`  result consumed.
- `mul_valid`  out  1  registered issue strobe to the multiplier.
- `mul_a`, `mul_b`  out  `WIDTH_DATA` each  registered operands to the multiplier.
- `mul_cout`, `mul_sum`  in  `2*WIDTH_DATA` each  carry-save multiplier output.
- `busy`  out  1  any operation in flight or any result buffered.

## Operation
**Per-requester state (registered).**
- `inflight[i]`: set on fire; cleared on result capture.
- `res_full[i]`: set on result capture; cleared on the `res_valid[i] && res_ready[i]` pop.

**Eligibility and arbitration.**
- Requester i is eligible when `req_valid[i] && !inflight[i] && !res_full[i]`. Registered state only, so a requester popped in cycle c is eligible again at c+1.
- Round-robin search starts at `last+1` and wraps modulo `N_REQ`. The first eligible requester gets `req_ready`.
- `last` updates to the granted index on fire. If nothing is granted, `last` holds.
- Fire = `req_valid[i] && req_ready[i]`. At most one fire per cycle.

**Issue.**
- On fire, the block registers `mul_a`/`mul_b` from the granted requester and sets `mul_valid`=1 for one cycle.
- `mul_a`/`mul_b` hold their value when there is no fire.

**Tag pipeline.**
- A shift register of depth `MUL_LAT+1` carries {valid, requester index} alongside the multiplier.
- When the tail tag is valid, the block captures `product = mul_sum + (mul_cout << 1)`, truncated to `2*WIDTH_DATA` bits (mod 2^(2W)). It writes the product into `res_data[idx]`, sets `res_full[idx]` and clears `inflight[idx]`.
- The multiplier outputs are ignored in cycles without a tail tag.

**Outputs.**
- `res_data[i]` is stable while `res_full[i]`.
- `busy` = `|inflight | |res_full`.

## Timing
**Reset.**
- Asynchronous; all registers clear.
- Outputs during and after reset: `req_ready`=0 (no valid), `res_valid`=0, `res_data`=0, `mul_valid`=0, `mul_a`=`mul_b`=0, `busy`=0.
- `last` resets to `N_REQ-1`, so requester 0 wins first.

**Latency.**
- Fire at cycle t → `mul_valid`/operands at t+1 → carry-save inputs sampled at t+1+`MUL_LAT` → `res_valid` high from t+2+`MUL_LAT`. This is 4 cycles at default.

**Throughput.**
- Aggregate: one issue per cycle.
- Per requester: one outstanding operation. Minimum re-issue is `MUL_LAT+3` cycles after a fire when `res_ready` is held high.

**Simultaneous events.**
- Result capture and pop never coincide for the same index, because there is only one outstanding operation per requester.
- A pop and a fire for different requesters in the same cycle are independent.

**Boundary conditions.**
- `res_ready` asserted without `res_valid`: ignored.
- `req_valid` dropped before grant: no effect. No commitment is implied before fire.
- Reset mid-operation: in-flight tags and buffered results are discarded. No `res_valid` appears after reset release until a new fire.

## Test plan
The bench multiplier model is a `MUL_LAT`-deep pipeline. It emits `cout=r` (random) and `sum = a*b - 2r`, mod 2^32.

- **Single request:** requester 0 fires `a=3`, `b=-5` at t → `res_valid[0]` at t+4 with `res_data[0]=0xFFFFFFF1`; `busy` 1 from t+1 until the pop.
- **Round-robin order:** all four requesters valid from reset, `res_ready` all 1 → fires to requesters 0,1,2,3 on four consecutive cycles. Next grants resume at 0 once its buffer pops; no requester is granted twice while another eligible requester waits.
- **Backpressure:** `res_ready[1]=0` for 20 cycles → requester 1 never regranted and `res_data[1]` stays stable. Requesters 0, 2 and 3 keep cycling. Releasing `res_ready[1]` → requester 1 is granted the cycle after the pop.
- **Carry-save resolve:** force `mul_cout=0x00008000`, `mul_sum=0x00000001` → `res_data=0x00010001`. Force `mul_cout=0xFFFFFFFF`, `mul_sum=0x00000003` → `res_data=0x00000001` (wrap).
- **Pointer fairness:** only requesters 2 and 3 valid after a grant to 2 → next grant goes to 3, then 2.
- **Reset mid-flight:** assert `rst_n=0` at t+2 after a fire, release at t+5 → no `res_valid`, `busy`=0, and requester 0 has priority on the first new request.
